// File: rtl/systolic_drain.sv
// Output collector for the systolic MAC array: de-skews the diagonal bottom-edge
// results into row-aligned words and streams them through a FWFT FIFO. Needs COLS >= 2.

module drain_skew #(
    parameter int W      = 32,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [STAGES-1:0][W-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int k = 1; k < STAGES; k++) sr[k] <= sr[k-1];
        end
    end

    assign q = sr[STAGES-1];
endmodule

module systolic_drain #(
    parameter int REG_WIDTH = 16,
    parameter int VECTOR    = 2,
    parameter int COLS      = 4,
    parameter int ROWS      = 4,
    parameter int DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tile_start,
    input  logic [COLS*VECTOR*REG_WIDTH-1:0] c_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COLS*VECTOR*REG_WIDTH-1:0] out_data,
    output logic                          out_last,
    output logic                          tile_done,
    output logic                          overflow,
    output logic                          start_err
);
    localparam int EW     = VECTOR * REG_WIDTH;
    localparam int DW     = COLS * EW;
    localparam int STAGES = COLS - 1;
    localparam int LASTN  = ROWS + COLS - 2;
    localparam int CW     = $clog2(ROWS + COLS);
    localparam int AW     = $clog2(DEPTH);
    localparam int NW     = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_C  = CW'(LASTN);
    localparam logic [CW-1:0] RLAST_C = CW'(ROWS - 1);
    localparam logic [NW-1:0] FULL_C  = NW'(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } row_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cur_cnt;
    logic          active;

    // The tile_start cycle itself counts as cnt=0 while the FSM still reads IDLE.
    assign active  = (state == CAPTURE) || (state == IDLE && tile_start);
    assign cur_cnt = (state == IDLE) ? '0 : cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tile_done <= 1'b0;
            start_err <= 1'b0;
        end else begin
            tile_done <= 1'b0;
            if (tile_start && state != IDLE) start_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (tile_start) begin
                        cnt <= CW'(1);
                        if (LAST_C == '0) begin
                            state     <= DONE;
                            tile_done <= 1'b1;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_C) begin
                        state     <= DONE;
                        tile_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Row-valid travels with column 0's sample and reaches the push point with the last column.
    logic              vld_in, last_in;
    logic [STAGES-1:0] vld_pipe, last_pipe;

    assign vld_in  = active && (cur_cnt <= RLAST_C);
    assign last_in = active && (cur_cnt == RLAST_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe  <= STAGES'({vld_pipe, vld_in});
            last_pipe <= STAGES'({last_pipe, last_in});
        end
    end

    logic [COLS-1:0][EW-1:0] aligned;

    for (genvar j = 0; j < COLS; j++) begin : g_col
        if (j == COLS - 1) begin : g_direct
            assign aligned[j] = c_in[j*EW +: EW];
        end else begin : g_skew
            drain_skew #(.W(EW), .STAGES(STAGES - j)) u_skew (
                .clk  (clk),
                .rst_n(rst_n),
                .d    (c_in[j*EW +: EW]),
                .q    (aligned[j])
            );
        end
    end

    logic          push, pop, push_ok, full, empty;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    row_t          mem [DEPTH];

    assign push    = vld_pipe[STAGES-1];
    assign empty   = (count == '0);
    assign full    = (count == FULL_C);
    assign pop     = !empty && out_ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push && !push_ok) overflow <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the empty gate keeps stale entries off the outputs.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= '{last: last_pipe[STAGES-1], data: aligned};
    end

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr].data;
    assign out_last  = !empty && mem[rd_ptr].last;
endmodule
